fifo_sync_param: RTL

//  Parametrised single-clock FIFO with its own storage, replacing the fixed 8-bit vendor FIFO between writer and reader.

---
 rtl/fifo_sync_param.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty levels,
// normal or show-ahead read mode, and sticky overflow/underflow error flags.
module fifo_sync_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned AF_LVL     = (2 ** ADDR_W) - 4,
  parameter int unsigned AE_LVL     = 4,
  parameter bit          SHOW_AHEAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wa;
  logic              ra;
  logic [CNT_W-1:0]  usedw_nxt;

  // Accept decisions use registered flags only, so full/empty arbitrate simultaneous access.
  always_comb begin
    wa        = wr_en & ~full;
    ra        = rd_en & ~empty;
    usedw_nxt = usedw + CNT_W'(wa) - CNT_W'(ra);
  end

  // Pointers, occupancy, level flags and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ra) rd_ptr <= rd_ptr + ADDR_W'(1);
      usedw        <= usedw_nxt;
      full         <= (usedw_nxt == CNT_W'(DEPTH));
      empty        <= (usedw_nxt == '0);
      almost_full  <= (usedw_nxt >= CNT_W'(AF_LVL));
      almost_empty <= (usedw_nxt <= CNT_W'(AE_LVL));
      overflow     <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= wr_data;
  end

  generate
    if (SHOW_AHEAD) begin : g_show_ahead
      // Head word is presented continuously; rd_en acknowledges it.
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_normal
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= ra;
          if (ra) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
